// File: rtl/decode_stage.sv
// RV64I decode stage: register file, operand/immediate selection, MEM/WB forwarding,
// hazard stalls and the DE->EXE latch. Define DECODE_CSR_EN to include the CSR file.
module decode_stage #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] DE_NPC,
    input  logic [31:0]     DE_IR,
    input  logic            DE_V,
    input  logic [31:0]     WB_IR,
    input  logic [XLEN-1:0] WB_RFD,
    input  logic [XLEN-1:0] WB_CSRFD,
    input  logic [XLEN-1:0] WB_ALU_RESULT,
    input  logic [XLEN-1:0] WB_MEM_RESULT,
    input  logic [XLEN-1:0] MEM_ALU_RESULT,
    input  logic            WB_ST_REG,
    input  logic            WB_ST_CSR,
    input  logic            WB_CS,
    input  logic [XLEN-1:0] WB_CAUSE,
    input  logic [31:0]     EXE_IR_OLD,
    input  logic [31:0]     MEM_IR_OLD,
    input  logic            MEM_STALL,
    output logic [XLEN-1:0] EXE_NPC,
    output logic [31:0]     EXE_IR,
    output logic            EXE_V,
    output logic [XLEN-1:0] EXE_ALU_ONE,
    output logic [XLEN-1:0] EXE_ALU_TWO,
    output logic [XLEN-1:0] EXE_RFD,
    output logic [XLEN-1:0] EXE_CSRFD,
    output logic            EXE_ECALL,
    output logic            v_de_br_stall,
    output logic [XLEN-1:0] DE_MTVEC
);

    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OPC_W  = 7;

    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_IMM32  = 7'b0011011;
    localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_REG32  = 7'b0111011;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] IR_ECALL = 32'h0000_0073;

    // Instruction classification helpers
    function automatic logic writes_rd(input logic [OPC_W-1:0] op, input logic [2:0] f3);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
            OP_IMM, OP_IMM32, OP_REG, OP_REG32: writes_rd = 1'b1;
            OP_SYSTEM:                          writes_rd = (f3 != 3'd0);
            default:                            writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [OPC_W-1:0] op, input logic [2:0] f3);
        case (op)
            OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
            OP_IMM, OP_IMM32, OP_REG, OP_REG32: uses_rs1 = 1'b1;
            OP_SYSTEM:                          uses_rs1 = (f3 != 3'd0) && !f3[2];
            default:                            uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
        case (op)
            OP_BRANCH, OP_STORE, OP_REG, OP_REG32: uses_rs2 = 1'b1;
            default:                               uses_rs2 = 1'b0;
        endcase
    endfunction

    logic [OPC_W-1:0] de_op;
    logic [2:0]       de_f3;
    logic [REG_W-1:0] de_rs1;
    logic [REG_W-1:0] de_rs2;
    logic [REG_W-1:0] wb_rd;
    logic [REG_W-1:0] mem_rd;
    logic [REG_W-1:0] exe_rd;
    logic             wb_wr;
    logic             mem_wr;
    logic             wb_is_load;
    logic             exe_is_load;

    assign de_op       = DE_IR[6:0];
    assign de_f3       = DE_IR[14:12];
    assign de_rs1      = DE_IR[19:15];
    assign de_rs2      = DE_IR[24:20];
    assign wb_rd       = WB_IR[11:7];
    assign mem_rd      = MEM_IR_OLD[11:7];
    assign exe_rd      = EXE_IR_OLD[11:7];
    assign wb_wr       = writes_rd(WB_IR[6:0], WB_IR[14:12]);
    assign mem_wr      = writes_rd(MEM_IR_OLD[6:0], MEM_IR_OLD[14:12]);
    assign wb_is_load  = (WB_IR[6:0] == OP_LOAD);
    assign exe_is_load = (EXE_IR_OLD[6:0] == OP_LOAD);

    // Register file; x0 is never written so it stays zero
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_ST_REG && (wb_rd != '0)) begin
            regs[wb_rd] <= WB_RFD;
        end
    end

    // Source operand read with forwarding: MEM beats WB beats write-through beats regfile
    logic [1:0][REG_W-1:0] rs_idx;
    logic [1:0][XLEN-1:0]  rs_val;

    assign rs_idx[0] = de_rs1;
    assign rs_idx[1] = de_rs2;

    always_comb begin
        rs_val = '0;
        for (int k = 0; k < 2; k++) begin
            if (rs_idx[k] != '0) begin
                if (mem_wr && (mem_rd == rs_idx[k])) begin
                    rs_val[k] = MEM_ALU_RESULT;
                end else if (wb_wr && (wb_rd == rs_idx[k])) begin
                    rs_val[k] = wb_is_load ? WB_MEM_RESULT : WB_ALU_RESULT;
                end else if (WB_ST_REG && (wb_rd == rs_idx[k])) begin
                    rs_val[k] = WB_RFD;
                end else begin
                    rs_val[k] = regs[rs_idx[k]];
                end
            end
        end
    end

    // Immediates, sign-extended to XLEN
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_c;

    assign imm_i = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
    assign imm_s = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]};
    assign imm_b = {{(XLEN-13){DE_IR[31]}}, DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){DE_IR[31]}}, DE_IR[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){DE_IR[31]}}, DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0};

    always_comb begin
        imm_c = imm_i;
        case (de_op)
            OP_STORE:          imm_c = imm_s;
            OP_BRANCH:         imm_c = imm_b;
            OP_JAL:            imm_c = imm_j;
            OP_LUI, OP_AUIPC:  imm_c = imm_u;
            default:           imm_c = imm_i;
        endcase
    end

    // ALU operand selection
    logic [XLEN-1:0] alu_one_c;
    logic [XLEN-1:0] alu_two_c;

    always_comb begin
        alu_one_c = rs_val[0];
        case (de_op)
            OP_LUI:                    alu_one_c = '0;
            OP_AUIPC, OP_JAL, OP_JALR: alu_one_c = DE_NPC - XLEN'(4);
            default:                   alu_one_c = rs_val[0];
        endcase
    end

    always_comb begin
        alu_two_c = imm_c;
        case (de_op)
            OP_REG, OP_REG32, OP_BRANCH: alu_two_c = rs_val[1];
            OP_JAL, OP_JALR:             alu_two_c = XLEN'(4);
            default:                     alu_two_c = imm_c;
        endcase
    end

    // Hazards: load-use inserts a bubble; control flow holds fetch but passes through
    logic load_use_c;
    logic ctrl_c;
    logic ecall_c;

    assign load_use_c = DE_V && exe_is_load && (exe_rd != '0) &&
                        ((uses_rs1(de_op, de_f3) && (de_rs1 == exe_rd)) ||
                         (uses_rs2(de_op) && (de_rs2 == exe_rd)));
    assign ctrl_c     = DE_V && ((de_op == OP_JAL) || (de_op == OP_JALR) || (de_op == OP_BRANCH));
    assign ecall_c    = DE_V && (DE_IR == IR_ECALL);

    assign v_de_br_stall = load_use_c || ctrl_c;

    logic [XLEN-1:0] csr_fd_c;

`ifdef DECODE_CSR_EN
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    logic [XLEN-1:0] csr_mstatus;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mscratch;
    logic [XLEN-1:0] csr_mepc;
    logic [XLEN-1:0] csr_mcause;
    logic [11:0]     wb_csr_addr;
    logic [11:0]     de_csr_addr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;

    assign wb_csr_addr = WB_IR[31:20];
    assign de_csr_addr = DE_IR[31:20];

    // Trap commit is written last so it overrides a CSR write to mcause
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            csr_mstatus  <= '0;
            csr_mtvec    <= MTVEC_RESET;
            csr_mscratch <= '0;
            csr_mepc     <= '0;
            csr_mcause   <= '0;
        end else begin
            if (WB_ST_CSR) begin
                case (wb_csr_addr)
                    CSR_MSTATUS:  csr_mstatus  <= WB_CSRFD;
                    CSR_MTVEC:    csr_mtvec    <= WB_CSRFD;
                    CSR_MSCRATCH: csr_mscratch <= WB_CSRFD;
                    CSR_MEPC:     csr_mepc     <= WB_CSRFD;
                    CSR_MCAUSE:   csr_mcause   <= WB_CSRFD;
                    default:      ;
                endcase
            end
            if (WB_CS) begin
                csr_mcause <= WB_CAUSE;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b1;
        case (de_csr_addr)
            CSR_MSTATUS:  csr_rdata = csr_mstatus;
            CSR_MTVEC:    csr_rdata = csr_mtvec;
            CSR_MSCRATCH: csr_rdata = csr_mscratch;
            CSR_MEPC:     csr_rdata = csr_mepc;
            CSR_MCAUSE:   csr_rdata = csr_mcause;
            default:      csr_hit   = 1'b0;
        endcase
        if (csr_hit && WB_ST_CSR && (wb_csr_addr == de_csr_addr)) begin
            csr_rdata = WB_CSRFD;
        end
        if (WB_CS && (de_csr_addr == CSR_MCAUSE)) begin
            csr_rdata = WB_CAUSE;
        end
    end

    assign csr_fd_c = (de_op == OP_SYSTEM) ? csr_rdata : '0;
    assign DE_MTVEC = csr_mtvec;
`else
    logic unused_csr_in;

    assign csr_fd_c      = '0;
    assign DE_MTVEC      = MTVEC_RESET;
    assign unused_csr_in = ^{WB_CSRFD, WB_ST_CSR, WB_CS, WB_CAUSE};
`endif

    // Instruction fields that only matter to later stages
    logic unused_ir_bits;
    assign unused_ir_bits = ^{WB_IR[31:15], MEM_IR_OLD[31:15], EXE_IR_OLD[31:12]};

    // DE->EXE pipeline latch; a load-use hazard captures a bubble
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            EXE_NPC     <= '0;
            EXE_IR      <= '0;
            EXE_V       <= 1'b0;
            EXE_ALU_ONE <= '0;
            EXE_ALU_TWO <= '0;
            EXE_RFD     <= '0;
            EXE_CSRFD   <= '0;
            EXE_ECALL   <= 1'b0;
        end else if (!MEM_STALL) begin
            EXE_NPC     <= DE_NPC;
            EXE_IR      <= DE_IR;
            EXE_V       <= DE_V && !load_use_c;
            EXE_ALU_ONE <= alu_one_c;
            EXE_ALU_TWO <= alu_two_c;
            EXE_RFD     <= rs_val[1];
            EXE_CSRFD   <= csr_fd_c;
            EXE_ECALL   <= ecall_c && !load_use_c;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/operand selection plus
// sequences for forwarding, hazards, latch hold, CSRs (DECODE_CSR_EN) and async reset.
module tb_decode_stage;

    logic        CLK;
    logic        RESET;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V;
    logic [31:0] WB_IR;
    logic [63:0] WB_RFD;
    logic [63:0] WB_CSRFD;
    logic [63:0] WB_ALU_RESULT;
    logic [63:0] WB_MEM_RESULT;
    logic [63:0] MEM_ALU_RESULT;
    logic        WB_ST_REG;
    logic        WB_ST_CSR;
    logic        WB_CS;
    logic [63:0] WB_CAUSE;
    logic [31:0] EXE_IR_OLD;
    logic [31:0] MEM_IR_OLD;
    logic        MEM_STALL;
    logic [63:0] EXE_NPC;
    logic [31:0] EXE_IR;
    logic        EXE_V;
    logic [63:0] EXE_ALU_ONE;
    logic [63:0] EXE_ALU_TWO;
    logic [63:0] EXE_RFD;
    logic [63:0] EXE_CSRFD;
    logic        EXE_ECALL;
    logic        v_de_br_stall;
    logic [63:0] DE_MTVEC;

    decode_stage dut (
        .CLK(CLK), .RESET(RESET),
        .DE_NPC(DE_NPC), .DE_IR(DE_IR), .DE_V(DE_V),
        .WB_IR(WB_IR), .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD),
        .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT),
        .MEM_ALU_RESULT(MEM_ALU_RESULT),
        .WB_ST_REG(WB_ST_REG), .WB_ST_CSR(WB_ST_CSR), .WB_CS(WB_CS), .WB_CAUSE(WB_CAUSE),
        .EXE_IR_OLD(EXE_IR_OLD), .MEM_IR_OLD(MEM_IR_OLD), .MEM_STALL(MEM_STALL),
        .EXE_NPC(EXE_NPC), .EXE_IR(EXE_IR), .EXE_V(EXE_V),
        .EXE_ALU_ONE(EXE_ALU_ONE), .EXE_ALU_TWO(EXE_ALU_TWO),
        .EXE_RFD(EXE_RFD), .EXE_CSRFD(EXE_CSRFD), .EXE_ECALL(EXE_ECALL),
        .v_de_br_stall(v_de_br_stall), .DE_MTVEC(DE_MTVEC)
    );

`ifdef DECODE_CSR_EN
    localparam bit CSR_ON = 1'b1;
`else
    localparam bit CSR_ON = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] npc;
        logic        v;
        logic [63:0] one;
        logic [63:0] two;
        logic [63:0] rfd;
        logic        ev;
        logic        stall;
        logic        ecall;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_de(input logic [31:0] ir, input logic [63:0] npc, input logic v);
        DE_IR  = ir;
        DE_NPC = npc;
        DE_V   = v;
    endtask

    task automatic clear_wb;
        WB_IR     = '0;
        WB_ST_REG = 1'b0;
        WB_ST_CSR = 1'b0;
        WB_CS     = 1'b0;
    endtask

    initial begin
        // x1..x5 preloaded to 100..500 before the table runs
        vecs[0]  = '{32'h002081B3, 64'h100,  1'b1, 64'd100, 64'd200, 64'd200, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFF10213, 64'h104,  1'b1, 64'd200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE51BC23, 64'h108,  1'b1, 64'd300, 64'hFFFF_FFFF_FFFF_FFF8, 64'd500, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h80000337, 64'h10C,  1'b1, 64'd0,   64'hFFFF_FFFF_8000_0000, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h00001397, 64'h1004, 1'b1, 64'h1000, 64'h1000, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h00208463, 64'h110,  1'b1, 64'd100, 64'd200, 64'd200, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h000100E7, 64'h2004, 1'b1, 64'h2000, 64'd4,  64'd0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h002081B3, 64'h114,  1'b0, 64'd100, 64'd200, 64'd200, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000073, 64'h3000, 1'b1, 64'd0,   64'd0,   64'd0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h40428433, 64'h118,  1'b1, 64'd500, 64'd400, 64'd400, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h80000493, 64'h11C,  1'b1, 64'd0,   64'hFFFF_FFFF_FFFF_F800, 64'd0, 1'b1, 1'b0, 1'b0};

        RESET = 1'b0;
        set_de('0, '0, 1'b0);
        clear_wb();
        WB_RFD = '0; WB_CSRFD = '0; WB_ALU_RESULT = '0; WB_MEM_RESULT = '0;
        MEM_ALU_RESULT = '0; WB_CAUSE = '0;
        EXE_IR_OLD = '0; MEM_IR_OLD = '0; MEM_STALL = 1'b0;
        #12;
        chk("rst_exe_v", 64'(EXE_V), 64'd0);
        chk("rst_exe_ir", 64'(EXE_IR), 64'd0);
        chk("rst_exe_npc", EXE_NPC, 64'd0);
        chk("rst_alu_one", EXE_ALU_ONE, 64'd0);
        chk("rst_alu_two", EXE_ALU_TWO, 64'd0);
        chk("rst_ecall", 64'(EXE_ECALL), 64'd0);
        chk("rst_mtvec", DE_MTVEC, 64'd0);
        RESET = 1'b1;

        // addi x1,x0,5 first instruction after reset
        set_de(32'h00508093, 64'd4, 1'b1);
        #1 chk("t1_stall", 64'(v_de_br_stall), 64'd0);
        tick();
        chk("t1_one", EXE_ALU_ONE, 64'd0);
        chk("t1_two", EXE_ALU_TWO, 64'd5);
        chk("t1_ir", 64'(EXE_IR), 64'h00508093);
        chk("t1_npc", EXE_NPC, 64'd4);
        chk("t1_v", 64'(EXE_V), 64'd1);

        // preload x1..x5
        set_de('0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            WB_IR     = {20'b0, 5'(i), 7'h33};
            WB_ST_REG = 1'b1;
            WB_RFD    = 64'(100 * i);
            tick();
        end
        clear_wb();

        for (int i = 0; i < 11; i++) begin
            set_de(vecs[i].ir, vecs[i].npc, vecs[i].v);
            #1 chk($sformatf("vec%0d_stall", i), 64'(v_de_br_stall), 64'(vecs[i].stall));
            tick();
            chk($sformatf("vec%0d_one", i), EXE_ALU_ONE, vecs[i].one);
            chk($sformatf("vec%0d_two", i), EXE_ALU_TWO, vecs[i].two);
            chk($sformatf("vec%0d_rfd", i), EXE_RFD, vecs[i].rfd);
            chk($sformatf("vec%0d_v", i), 64'(EXE_V), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_ecall", i), 64'(EXE_ECALL), 64'(vecs[i].ecall));
            chk($sformatf("vec%0d_ir", i), 64'(EXE_IR), 64'(vecs[i].ir));
            chk($sformatf("vec%0d_npc", i), EXE_NPC, vecs[i].npc);
        end

        // WB forwarding of add x1 with regfile write, then regfile readback
        WB_IR = 32'h000000B3; WB_ST_REG = 1'b1; WB_RFD = 64'd7; WB_ALU_RESULT = 64'd7;
        set_de(32'h00008113, 64'h200, 1'b1);
        tick();
        chk("t2_wb_fwd", EXE_ALU_ONE, 64'd7);
        clear_wb();
        tick();
        chk("t2_rf_read", EXE_ALU_ONE, 64'd7);

        // write-through: regfile write by a non-forwarding WB instruction
        WB_IR = 32'h00000180; WB_ST_REG = 1'b1; WB_RFD = 64'h333; WB_ALU_RESULT = 64'hDEAD;
        set_de(32'h00018113, 64'h204, 1'b1);
        tick();
        chk("wt_read", EXE_ALU_ONE, 64'h333);

        // WB load forwards load data
        WB_IR = 32'h0000B083; WB_ST_REG = 1'b0; WB_MEM_RESULT = 64'h55; WB_ALU_RESULT = 64'h99;
        set_de(32'h00008113, 64'h208, 1'b1);
        tick();
        chk("wb_load_fwd", EXE_ALU_ONE, 64'h55);

        // MEM beats WB; rs2 forwarding
        WB_IR = 32'h000000B3; WB_ALU_RESULT = 64'h77;
        MEM_IR_OLD = 32'h00508093; MEM_ALU_RESULT = 64'd9;
        set_de(32'h00008113, 64'h20C, 1'b1);
        tick();
        chk("t3_mem_fwd", EXE_ALU_ONE, 64'd9);
        set_de(32'h001101B3, 64'h210, 1'b1);
        tick();
        chk("t3_rs2_one", EXE_ALU_ONE, 64'd200);
        chk("t3_rs2_two", EXE_ALU_TWO, 64'd9);
        chk("t3_rs2_rfd", EXE_RFD, 64'd9);
        clear_wb();

        // no forwarding into x0
        MEM_IR_OLD = 32'h00500013; MEM_ALU_RESULT = 64'h1234;
        set_de(32'h00000113, 64'h214, 1'b1);
        tick();
        chk("x0_no_fwd", EXE_ALU_ONE, 64'd0);
        MEM_IR_OLD = '0;

        // load-use on rs1
        EXE_IR_OLD = 32'h0000B083;
        set_de(32'h00008113, 64'h300, 1'b1);
        #1 chk("lu_rs1_stall", 64'(v_de_br_stall), 64'd1);
        tick();
        chk("lu_rs1_bubble", 64'(EXE_V), 64'd0);
        // load-use on rs2
        EXE_IR_OLD = 32'h0000B103;
        set_de(32'h002081B3, 64'h304, 1'b1);
        #1 chk("lu_rs2_stall", 64'(v_de_br_stall), 64'd1);
        tick();
        chk("lu_rs2_bubble", 64'(EXE_V), 64'd0);
        // load to a register not used
        set_de(32'h00008113, 64'h308, 1'b1);
        #1 chk("lu_nomatch_stall", 64'(v_de_br_stall), 64'd0);
        tick();
        chk("lu_nomatch_v", 64'(EXE_V), 64'd1);
        // invalid decode slot and load to x0
        EXE_IR_OLD = 32'h0000B083;
        set_de(32'h00008113, 64'h30C, 1'b0);
        #1 chk("lu_dev0_stall", 64'(v_de_br_stall), 64'd0);
        EXE_IR_OLD = 32'h0000B003;
        set_de(32'h00000113, 64'h310, 1'b1);
        #1 chk("lu_x0_stall", 64'(v_de_br_stall), 64'd0);
        // jal behind a load: control stall but passes through
        EXE_IR_OLD = 32'h0000B083;
        set_de(32'h0000006F, 64'h40, 1'b1);
        #1 chk("jal_stall", 64'(v_de_br_stall), 64'd1);
        tick();
        chk("jal_v", 64'(EXE_V), 64'd1);
        chk("jal_two", EXE_ALU_TWO, 64'd4);
        chk("jal_one", EXE_ALU_ONE, 64'h3C);
        EXE_IR_OLD = '0;

        // latch hold under MEM_STALL; regfile write still happens
        set_de(32'h40428433, 64'h500, 1'b1);
        tick();
        chk("hold_pre_one", EXE_ALU_ONE, 64'd500);
        MEM_STALL = 1'b1;
        WB_IR = 32'h000004B3; WB_ST_REG = 1'b1; WB_RFD = 64'hABC; WB_ALU_RESULT = 64'hABC;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       set_de(32'h00008113, 64'h600, 1'b1);
                1:       set_de(32'h002081B3, 64'h604, 1'b1);
                default: set_de(32'h00000073, 64'h608, 1'b1);
            endcase
            tick();
            clear_wb();
            chk($sformatf("hold%0d_ir", k), 64'(EXE_IR), 64'h40428433);
            chk($sformatf("hold%0d_one", k), EXE_ALU_ONE, 64'd500);
            chk($sformatf("hold%0d_npc", k), EXE_NPC, 64'h500);
            chk($sformatf("hold%0d_ecall", k), 64'(EXE_ECALL), 64'd0);
        end
        MEM_STALL = 1'b0;
        tick();
        chk("ecall_after_release", 64'(EXE_ECALL), 64'd1);
        chk("ecall_ir", 64'(EXE_IR), 64'h00000073);
        set_de(32'h00048513, 64'h60C, 1'b1);
        tick();
        chk("stall_rf_write", EXE_ALU_ONE, 64'hABC);
        chk("ecall_cleared", 64'(EXE_ECALL), 64'd0);

        // CSR file: mtvec write, mcause write vs trap commit
        set_de(32'h00000013, 64'h700, 1'b0);
        WB_IR = 32'h30500073; WB_ST_CSR = 1'b1; WB_CSRFD = 64'h80;
        tick();
        clear_wb();
        chk("mtvec_write", DE_MTVEC, CSR_ON ? 64'h80 : 64'h0);
        set_de(32'h305022F3, 64'h704, 1'b1);
        tick();
        chk("csr_read_mtvec", EXE_CSRFD, CSR_ON ? 64'h80 : 64'h0);
        WB_IR = 32'h34200073; WB_ST_CSR = 1'b1; WB_CSRFD = 64'h1; WB_CS = 1'b1; WB_CAUSE = 64'hB;
        set_de(32'h00000013, 64'h708, 1'b0);
        tick();
        clear_wb();
        set_de(32'h342022F3, 64'h70C, 1'b1);
        tick();
        chk("mcause_trap_wins", EXE_CSRFD, CSR_ON ? 64'hB : 64'h0);
        set_de(32'h30500293, 64'h710, 1'b1);
        tick();
        chk("csr_non_system", EXE_CSRFD, 64'd0);
        set_de(32'h7C0022F3, 64'h714, 1'b1);
        tick();
        chk("csr_unknown_addr", EXE_CSRFD, 64'd0);
        chk("pre_reset_v", 64'(EXE_V), 64'd1);

        // asynchronous reset mid-cycle
        set_de('0, '0, 1'b0);
        #2 RESET = 1'b0;
        #1;
        chk("arst_v", 64'(EXE_V), 64'd0);
        chk("arst_ir", 64'(EXE_IR), 64'd0);
        chk("arst_npc", EXE_NPC, 64'd0);
        chk("arst_one", EXE_ALU_ONE, 64'd0);
        chk("arst_two", EXE_ALU_TWO, 64'd0);
        chk("arst_mtvec", DE_MTVEC, 64'd0);
        #1 RESET = 1'b1;
        set_de(32'h00048513, 64'h800, 1'b1);
        tick();
        chk("arst_rf_cleared", EXE_ALU_ONE, 64'd0);
        chk("arst_resume_v", 64'(EXE_V), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
